// File: rtl/out_port_arbiter.sv
// Per-output-port wormhole arbiter: locks the output to one input from head to tail flit.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module out_port_arbiter #(
  parameter int N_PORTS = 5,
  parameter int PTR_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] grant,
  output logic               xfer,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             r_state;
  logic [N_PORTS-1:0] r_grant;
  logic               r_busy;
  logic [PTR_W-1:0]   r_owner;

  logic [N_PORTS-1:0] w_own_mask;
  logic [N_PORTS-1:0] w_others;
  logic [N_PORTS-1:0] w_pick_idle;
  logic [N_PORTS-1:0] w_pick_tail;
  logic               w_xfer;
  logic               w_tail_xfer;

  // First set bit of req_v scanning start, start+1, ... modulo N_PORTS.
  function automatic logic [N_PORTS-1:0] f_pick(input logic [N_PORTS-1:0] req_v,
                                                input int                 start);
    logic [N_PORTS-1:0] res;
    logic               found;
    int                 idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = start + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (!found && req_v[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] f_idx(input logic [N_PORTS-1:0] onehot);
    logic [PTR_W-1:0] res;
    res = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (onehot[k]) res = PTR_W'(k);
    end
    return res;
  endfunction

  assign w_own_mask  = N_PORTS'(1) << r_owner;
  assign w_others    = req & ~w_own_mask;
  assign w_xfer      = (|(r_grant & req)) & out_ready;
  // r_grant is zero in IDLE, so a stale r_owner can never fake a tail transfer.
  assign w_tail_xfer = w_xfer & (|(w_own_mask & tail));

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_owner_inc;

  assign w_owner_inc = (r_owner == PTR_W'(N_PORTS - 1)) ? '0 : r_owner + 1'b1;
  assign w_pick_idle = f_pick(req, int'(r_rr_ptr));
  assign w_pick_tail = f_pick(w_others, int'(w_owner_inc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if ((r_state == LOCK) && w_tail_xfer) begin
      r_rr_ptr <= w_owner_inc;
    end
  end
`else
  assign w_pick_idle = f_pick(req, 0);
  assign w_pick_tail = f_pick(w_others, 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state <= LOCK;
            r_grant <= w_pick_idle;
            r_owner <= f_idx(w_pick_idle);
            r_busy  <= 1'b1;
          end
        end
        LOCK: begin
          // Release on tail; hand over in the same cycle when someone else is waiting.
          if (w_tail_xfer) begin
            if (|w_others) begin
              r_grant <= w_pick_tail;
              r_owner <= f_idx(w_pick_tail);
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign busy  = r_busy;
  assign xfer  = w_xfer;

endmodule
